muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_datapath.sv | 117 +++++++++++
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, op bit indices and FSM encoding for the iterative M-extension unit.
// Defining MULDIV_DIV_EN adds the DIV state and the divider datapath.
package muldiv_pkg;

    localparam int XLEN = 32;

    // Bit positions inside the one-hot op vector, same order as decoder out_signal[46:39]
    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHSU = 2;
    localparam int OP_MULHU  = 3;
    localparam int OP_DIV    = 4;
    localparam int OP_DIVU   = 5;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 7;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] SMIN      = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
`ifdef MULDIV_DIV_EN
        ,
        DIV  = 2'd3
`endif
    } state_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitudes, radix-2 shift-add multiplier, restoring divider and sign fix-up.
// The divider half is only built when MULDIV_DIV_EN is defined.
module muldiv_datapath #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [7:0]      load_op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [7:0]      run_op,
    output logic [XLEN-1:0] res_next
);
    import muldiv_pkg::*;

    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   acc_n;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   lo_n;
    logic [XLEN-1:0]   mcand;
    logic              neg_main;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic              unused_op_bits;

`ifdef MULDIV_DIV_EN
    logic              neg_rem;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              take;
`endif

    assign unused_op_bits = ^{load_op, run_op};

    always_comb begin
        a_signed = load_op[OP_MULH] | load_op[OP_MULHSU];
        b_signed = load_op[OP_MULH];
`ifdef MULDIV_DIV_EN
        a_signed = a_signed | load_op[OP_DIV] | load_op[OP_REM];
        b_signed = b_signed | load_op[OP_DIV] | load_op[OP_REM];
`endif
        a_neg = a_signed & rs1_val[XLEN-1];
        b_neg = b_signed & rs2_val[XLEN-1];
        a_mag = a_neg ? -rs1_val : rs1_val;
        b_mag = b_neg ? -rs2_val : rs2_val;
    end

    // acc:lo holds the running product (acc high half) or remainder:quotient for divides
    always_comb begin
        add_sum = {1'b0, acc};
        if (lo[0]) begin
            add_sum = {1'b0, acc} + {1'b0, mcand};
        end
        acc_n = add_sum[XLEN:1];
        lo_n  = {add_sum[0], lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {acc, lo[XLEN-1]};
        diff    = {1'b0, shifted[XLEN-1:0]} - {1'b0, mcand};
        take    = shifted[XLEN] | ~diff[XLEN];
        if (|run_op[OP_REMU:OP_DIV]) begin
            acc_n = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_n  = {lo[XLEN-2:0], take};
        end
`endif
    end

    // Result of the iteration now in progress, with the sign put back
    always_comb begin
        prod     = {acc_n, lo_n};
        prod_s   = neg_main ? -prod : prod;
        res_next = run_op[OP_MUL] ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        if (run_op[OP_DIV] | run_op[OP_DIVU]) begin
            res_next = neg_main ? -lo_n : lo_n;
        end else if (run_op[OP_REM] | run_op[OP_REMU]) begin
            res_next = neg_rem ? -acc_n : acc_n;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            lo       <= '0;
            mcand    <= '0;
            neg_main <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem  <= 1'b0;
`endif
        end else if (load) begin
            acc      <= '0;
            lo       <= b_mag;
            mcand    <= a_mag;
            neg_main <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            neg_rem  <= a_neg;
            if (|load_op[OP_REMU:OP_DIV]) begin
                lo    <= a_mag;
                mcand <= b_mag;
            end
`endif
        end else if (step) begin
            acc <= acc_n;
            lo  <= lo_n;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit: FSM, iteration counter, special-case decode and output handshake.
// Defining MULDIV_DIV_EN enables divide/remainder ops; otherwise they return err.
module muldiv_ctrl #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            err
);
    import muldiv_pkg::*;

    state_t          state;
    state_t          state_n;
    logic [4:0]      cnt;
    logic [4:0]      cnt_n;
    logic [7:0]      op_q;
    logic [4:0]      rd_q;
    logic            load;
    logic            step;
    logic            fin;
    logic            fin_err;
    logic [XLEN-1:0] fin_res;
    logic [XLEN-1:0] dp_res;
    logic            op_legal;
    logic            is_special;
    logic [XLEN-1:0] special_res;

    // Requests that finish in one cycle: bad op encodings and the divide corner cases
    always_comb begin
        op_legal    = is_onehot8(op);
        is_special  = 1'b0;
        special_res = '0;
`ifdef MULDIV_DIV_EN
        if (op_legal && (|op[OP_REMU:OP_DIV])) begin
            if (rs2_val == '0) begin
                is_special  = 1'b1;
                special_res = (op[OP_DIV] | op[OP_DIVU]) ? DIV0_QUOT : rs1_val;
            end else if ((op[OP_DIV] | op[OP_REM]) && rs1_val == SMIN && rs2_val == '1) begin
                is_special  = 1'b1;
                special_res = op[OP_DIV] ? SMIN : '0;
            end
        end
`else
        op_legal = op_legal & ~(|op[OP_REMU:OP_DIV]);
`endif
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_res = '0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    load = 1'b1;
                    if (!op_legal) begin
                        state_n = DONE;
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else if (is_special) begin
                        state_n = DONE;
                        fin     = 1'b1;
                        fin_res = special_res;
`ifdef MULDIV_DIV_EN
                    end else if (|op[OP_REMU:OP_DIV]) begin
                        state_n = DIV;
`endif
                    end else begin
                        state_n = MUL;
                    end
                end
            end
            MUL: begin
                step  = 1'b1;
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    fin_res = dp_res;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                step  = 1'b1;
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    fin_res = dp_res;
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Flush beats everything, including a start in the same cycle
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            load    = 1'b0;
            step    = 1'b0;
            fin     = 1'b0;
            fin_err = 1'b0;
            fin_res = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            if (load) begin
                op_q <= op;
                rd_q <= rd_in;
            end
            done   <= fin;
            result <= fin_res;
            err    <= fin_err;
            rd_out <= fin ? (load ? rd_in : rd_q) : 5'd0;
        end
    end

    assign busy = (state != IDLE);

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .load_op (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .run_op  (op_q),
        .res_next(dp_res)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus scoreboard, then abort/reset/hold sequences.
// Expectations follow MULDIV_DIV_EN when the bench is compiled with it.
module tb_muldiv_ctrl;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        err;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1_val(rs1_val),
        .rs2_val(rs2_val),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic addVec(input string nm, input logic [7:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic e,
                          input int lat, input bit is_div);
        vec_t v;
        v.name = nm;
        v.op   = o;
        v.a    = a;
        v.b    = b;
        v.rd   = 5'(vecs.size() + 1);
        v.res  = r;
        v.err  = e;
        v.lat  = lat;
`ifndef MULDIV_DIV_EN
        if (is_div) begin
            v.res = 32'd0;
            v.err = 1'b1;
            v.lat = 1;
        end
`endif
        vecs.push_back(v);
    endtask

    // Reference arithmetic on 64-bit integers, independent of any shift-add structure
    function automatic void model(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        up;
        r   = 32'd0;
        e   = 1'b0;
        lat = 33;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            8'h01: begin up = ua * ub; r = up[31:0];  end
            8'h02: begin sp = sa * sb; r = sp[63:32]; end
            8'h04: begin sp = sa * $signed(ub); r = sp[63:32]; end
            8'h08: begin up = ua * ub; r = up[63:32]; end
`ifdef MULDIV_DIV_EN
            8'h10: begin
                if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 32'h80000000; lat = 1; end
                else r = $signed(a) / $signed(b);
            end
            8'h20: begin
                if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                else r = a / b;
            end
            8'h40: begin
                if (b == 0) begin r = a; lat = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 32'd0; lat = 1; end
                else r = $signed(a) % $signed(b);
            end
            8'h80: begin
                if (b == 0) begin r = a; lat = 1; end
                else r = a % b;
            end
`endif
            default: begin r = 32'd0; e = 1'b1; lat = 1; end
        endcase
    endfunction

    task automatic applyStimulus(input vec_t v, input bit hold_start);
        @(negedge clk);
        op      = v.op;
        rs1_val = v.a;
        rs2_val = v.b;
        rd_in   = v.rd;
        start   = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        start   = hold_start;
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in   = 5'h1F;
        op      = 8'h08;
    endtask

    task automatic checkOutput(input int drop_start_at);
        int   cyc = 0;
        bit   seen = 0;
        bit   busy_ok = 1;
        bit   quiet_ok = 1;
        vec_t e;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == drop_start_at) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (result !== 32'd0 || rd_out !== 5'd0 || err !== 1'b0) quiet_ok = 0;
            end
        end
        start = 1'b0;
        compare("scoreboard entry present", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        compare({e.name, " done seen"}, 64'(seen), 64'd1);
        if (seen) begin
            compare({e.name, " result"}, result, e.res);
            compare({e.name, " err"}, err, e.err);
            compare({e.name, " rd_out"}, rd_out, e.rd);
            compare({e.name, " latency"}, cyc, e.lat);
            compare({e.name, " busy at done"}, busy, 1);
            compare({e.name, " busy while running"}, 64'(busy_ok), 64'd1);
            compare({e.name, " outputs zero before done"}, 64'(quiet_ok), 64'd1);
            @(negedge clk);
            compare({e.name, " done one cycle"}, done, 0);
            compare({e.name, " idle after done"}, busy, 0);
        end
    endtask

    task automatic driveOnly(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic fl);
        @(negedge clk);
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        flush   = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic watchNoDone(input string nm, input int n);
        int hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (done !== 1'b0) hits++;
        end
        compare(nm, hits, 0);
    endtask

    initial begin
        vec_t        v;
        logic [7:0]  abort_op;
        logic [31:0] abort_a;
        logic [31:0] abort_res;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 8'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd_in   = 5'd0;
        flush   = 1'b0;

        #12;
        compare("reset busy/done/err", {busy, done, err}, 3'b000);
        compare("reset result/rd_out", {result, rd_out}, 37'd0);
        @(negedge clk);
        rst = 1'b0;

        addVec("mul 7x6",              8'h01, 32'd7,        32'd6,        32'h0000002A, 0, 33, 0);
        addVec("mulhu -1x-1",          8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33, 0);
        addVec("mulh -1x-1",           8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 33, 0);
        addVec("mulhsu -1x2",          8'h04, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 33, 0);
        addVec("mul -1x5",             8'h01, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB, 0, 33, 0);
        addVec("mulh -1x5",            8'h02, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 0, 33, 0);
        addVec("mulh smin x smin",     8'h02, 32'h80000000, 32'h80000000, 32'h40000000, 0, 33, 0);
        addVec("mulhu smin x 2",       8'h08, 32'h80000000, 32'd2,        32'h00000001, 0, 33, 0);
        addVec("div -7/2",             8'h10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33, 1);
        addVec("rem -7/2",             8'h40, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33, 1);
        addVec("divu 0xFFFFFFF9/2",    8'h20, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 0, 33, 1);
        addVec("remu 0xFFFFFFF9/2",    8'h80, 32'hFFFFFFF9, 32'd2,        32'h00000001, 0, 33, 1);
        addVec("divu 10/2",            8'h20, 32'd10,       32'd2,        32'h00000005, 0, 33, 1);
        addVec("divu 5/0",             8'h20, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1,  1);
        addVec("remu 5/0",             8'h80, 32'd5,        32'd0,        32'h00000005, 0, 1,  1);
        addVec("div 5/0",              8'h10, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1,  1);
        addVec("rem -7/0",             8'h40, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0, 1,  1);
        addVec("div smin/-1",          8'h10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1,  1);
        addVec("rem smin/-1",          8'h40, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 1,  1);
        addVec("illegal op 0x03",      8'h03, 32'd9,        32'd9,        32'h00000000, 1, 1,  0);
        addVec("illegal op 0x00",      8'h00, 32'd9,        32'd9,        32'h00000000, 1, 1,  0);
        addVec("illegal op 0x81",      8'h81, 32'd9,        32'd9,        32'h00000000, 1, 1,  0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], 1'b0);
            checkOutput(0);
        end

        for (int i = 0; i < 12; i++) begin
            v.name = $sformatf("random #%0d", i);
            v.op   = 8'h01 << $urandom_range(0, 7);
            v.a    = $urandom;
            v.b    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            v.rd   = 5'($urandom_range(1, 31));
            model(v.op, v.a, v.b, v.res, v.err, v.lat);
            applyStimulus(v, 1'b0);
            checkOutput(0);
        end

        // start held high and inputs changing while busy must not disturb the running op
        v.name = "mul 3x5 start held";
        v.op   = 8'h01;
        v.a    = 32'd3;
        v.b    = 32'd5;
        v.rd   = 5'd7;
        v.res  = 32'd15;
        v.err  = 1'b0;
        v.lat  = 33;
        applyStimulus(v, 1'b1);
        checkOutput(20);

        // flush at cycle 10 of a multiply
        driveOnly(8'h01, 32'd7, 32'd6, 5'd3, 1'b0);
        repeat (10) @(negedge clk);
        compare("flush: busy before flush", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        compare("flush: busy low in cycle 11", busy, 0);
        watchNoDone("flush: no done afterwards", 40);

        // flush and start together: request dropped
        driveOnly(8'h01, 32'd7, 32'd6, 5'd4, 1'b1);
        @(negedge clk);
        compare("flush+start: stays idle", busy, 0);
        watchNoDone("flush+start: no done", 40);

`ifdef MULDIV_DIV_EN
        abort_op  = 8'h10;
        abort_a   = 32'hFFFFFFF9;
        abort_res = 32'hFFFFFFFD;
`else
        abort_op  = 8'h01;
        abort_a   = 32'd21;
        abort_res = 32'd42;
`endif
        // reset mid-operation, asserted away from any clock edge
        driveOnly(abort_op, abort_a, 32'd2, 5'd9, 1'b0);
        repeat (5) @(negedge clk);
        compare("mid-op reset: busy before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        compare("mid-op reset: busy cleared at once", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        watchNoDone("mid-op reset: no later done", 40);

        // reset during the done cycle clears the registered outputs immediately
        driveOnly(abort_op, abort_a, 32'd2, 5'd21, 1'b0);
        repeat (33) @(negedge clk);
        compare("done-cycle reset: done before", done, 1);
        compare("done-cycle reset: result before", result, abort_res);
        #1;
        rst = 1'b1;
        #1;
        compare("done-cycle reset: done/err/busy cleared", {done, err, busy}, 3'b000);
        compare("done-cycle reset: result/rd_out cleared", {result, rd_out}, 37'd0);
        @(negedge clk);
        rst = 1'b0;
        watchNoDone("done-cycle reset: no later done", 40);

        compare("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
